dmem_resp: RTL

//   Responder end of the core's data-SRAM interface (dat_a/we/wd/re/rd): a synchronous

---
 rtl/dmem_resp_if.sv | 29 ++
 rtl/dmem_resp.sv | 113 +++++++++++
 2 files changed

// File: rtl/dmem_resp_if.sv
// Bus bundle between the core/boot loader and the data-memory responder.
// Carries the core SRAM port (dat_*) and the loader word-write port (ld_*).
interface dmem_resp_if;
  logic [15:0] dat_a;
  logic [3:0]  dat_we;
  logic [31:0] dat_wd;
  logic [3:0]  dat_re;
  logic [31:0] dat_rd;
  logic        dat_rvld;
  logic        dat_err;
  logic        ld_req;
  logic [15:0] ld_a;
  logic [31:0] ld_wd;
  logic        ld_gnt;

  // Handshakes: the core port never stalls; any dat_we/dat_re bit is taken on the
  // next rising edge, and each read returns exactly one dat_rvld pulse RD_LAT edges
  // later. The loader raises ld_req and holds ld_a/ld_wd stable. The word is written
  // on the rising edge of a cycle in which ld_req and ld_gnt are both high.
  modport master (
    output dat_a, dat_we, dat_wd, dat_re, ld_req, ld_a, ld_wd,
    input  dat_rd, dat_rvld, dat_err, ld_gnt
  );

  modport slave (
    input  dat_a, dat_we, dat_wd, dat_re, ld_req, ld_a, ld_wd,
    output dat_rd, dat_rvld, dat_err, ld_gnt
  );
endinterface

// File: rtl/dmem_resp.sv
// Word-organised data SRAM with byte-lane writes/reads, a RD_LAT-deep read pipeline,
// out-of-range flagging and a low-priority full-word loader write port.
module dmem_resp #(
  parameter int DEPTH  = 4096,
  parameter int RD_LAT = 1
) (
  input logic        clk,
  input logic        rst,
  dmem_resp_if.slave bus
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [14:0] DEPTH_W = 15'(DEPTH);
  localparam int          LAST    = RD_LAT - 1;

  logic [31:0] mem [DEPTH];

  logic          core_wr;
  logic          core_rd;
  logic          core_acc;
  logic [13:0]   core_idx;
  logic [13:0]   ld_idx;
  logic          core_oor;
  logic          ld_oor;
  logic [AW-1:0] core_waddr;
  logic [AW-1:0] ld_waddr;
  logic          ld_fire;
  logic          wr_err_q;
  logic          unused_lsbs;

  // Read pipeline: per-stage valid, range error, lane enables and raw word.
  logic [RD_LAT-1:0] pv;
  logic [RD_LAT-1:0] pe;
  logic [3:0]        pm [RD_LAT];
  logic [31:0]       pd [RD_LAT];
  logic [31:0]       lane_mask;

  assign core_wr    = |bus.dat_we;
  assign core_rd    = |bus.dat_re;
  assign core_acc   = core_wr | core_rd;
  assign core_idx   = bus.dat_a[15:2];
  assign ld_idx     = bus.ld_a[15:2];
  // Address bits above the array index only take part in the range check.
  assign core_oor   = {1'b0, core_idx} >= DEPTH_W;
  assign ld_oor     = {1'b0, ld_idx} >= DEPTH_W;
  assign core_waddr = core_idx[AW-1:0];
  assign ld_waddr   = ld_idx[AW-1:0];

  assign unused_lsbs = ^{bus.dat_a[1:0], bus.ld_a[1:0]};

  assign bus.ld_gnt = bus.ld_req & ~core_acc & ~rst;
  assign ld_fire    = bus.ld_gnt;

  // Array storage: no reset, core lane writes win over the loader.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (core_wr) begin
        if (!core_oor) begin
          for (int i = 0; i < 4; i++) begin
            if (bus.dat_we[i]) begin
              mem[core_waddr][8*i +: 8] <= bus.dat_wd[8*i +: 8];
            end
          end
        end
      end else if (ld_fire && !ld_oor) begin
        mem[ld_waddr] <= bus.ld_wd;
      end
    end
  end

  // Raw read word is sampled before this edge's write lands (read-before-write).
  always_ff @(posedge clk) begin
    if (core_rd) begin
      pd[0] <= mem[core_waddr];
    end
    for (int i = 1; i < RD_LAT; i++) begin
      pd[i] <= pd[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pv       <= '0;
      pe       <= '0;
      wr_err_q <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
        pm[i] <= 4'h0;
      end
    end else begin
      pv[0]    <= core_rd;
      pe[0]    <= core_rd & core_oor;
      pm[0]    <= bus.dat_re;
      wr_err_q <= core_wr & core_oor;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        pm[i] <= pm[i-1];
      end
    end
  end

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < 4; i++) begin
      lane_mask[8*i +: 8] = {8{pm[LAST][i]}};
    end
  end

  // The bus carries zeros whenever no valid in-range read is being returned.
  assign bus.dat_rvld = pv[LAST];
  assign bus.dat_rd   = (pv[LAST] && !pe[LAST]) ? (pd[LAST] & lane_mask) : 32'h0;
  assign bus.dat_err  = wr_err_q | (pv[LAST] & pe[LAST]);

endmodule
